// File: rtl/risac_arb_pkg.sv
// risac_arb_pkg: shared types and constants for the risac memory arbiter.
// Holds the default NOP, the data-side state encoding and the fetch bundle.
package risac_arb_pkg;

  localparam logic [31:0] ARB_NOP = 32'h0000_0013;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_RESP = 1'b1
  } dstate_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fetch_rsp_t;

endpackage

// File: rtl/risac_fetch_buf.sv
// risac_fetch_buf: one-entry fetch response stream and instruction mux.
// In: clk, rst_n, acceptI, iIbusAddr, iMemData. Out: oIbusData, oIbusIAddr.
module risac_fetch_buf
  import risac_arb_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = ARB_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acceptI,
  input  logic [31:0] iIbusAddr,
  input  logic [31:0] iMemData,
  output logic [31:0] oIbusData,
  output logic [31:0] oIbusIAddr
);

  logic       fetchPend;
  logic [31:0] pendAddr;
  logic       hValid;
  fetch_rsp_t hold;
  fetch_rsp_t pres;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPend <= 1'b0;
      pendAddr  <= '0;
      hValid    <= 1'b0;
      hold      <= '0;
    end else begin
      fetchPend <= acceptI;
      if (acceptI) begin
        pendAddr <= iIbusAddr;
      end
      // Read data lives only one cycle on the bus;
      // park it if decode did not take it.
      if (acceptI) begin
        hValid <= 1'b0;
      end else if (fetchPend) begin
        hValid     <= 1'b1;
        hold.addr  <= pendAddr;
        hold.instr <= iMemData;
      end
    end
  end

  // fetchPend and hValid are never set together:
  // capture needs !acceptI, and fetchPend needs acceptI.
  always_comb begin
    pres = '{addr: hold.addr, instr: NOP_INSTR};
    unique case (1'b1)
      fetchPend: pres = '{addr: pendAddr, instr: iMemData};
      hValid:    pres = hold;
      default:   pres = '{addr: hold.addr, instr: NOP_INSTR};
    endcase
  end

  assign oIbusData  = pres.instr;
  assign oIbusIAddr = pres.addr;

endmodule

// File: rtl/risac_mem_arbiter.sv
// risac_mem_arbiter: shares one 1-cycle-latency memory port between the
// core's fetch and data buses; data wins. Optional RISAC_ARB_PERF_EN adds counters.
module risac_mem_arbiter
  import risac_arb_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = ARB_NOP
`ifdef RISAC_ARB_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iIbusAddr,
  output logic [31:0] oIbusData,
  output logic [31:0] oIbusIAddr,
  output logic        oIbusWait,
  input  logic        iFetchHold,
  input  logic [31:0] iDbusAddr,
  input  logic        iDbusWe,
  input  logic [31:0] iDbusData,
  input  logic        iDbusRead,
  input  logic [3:0]  iDbusByteEn,
  output logic [31:0] oDbusData,
  output logic        oDbusWait,
  output logic [31:0] oMemAddr,
  output logic        oMemRead,
  output logic        oMemWe,
  output logic [31:0] oMemData,
  output logic [3:0]  oMemByteEn,
  input  logic [31:0] iMemData,
`ifdef RISAC_ARB_PERF_EN
  output logic [PERF_W-1:0] oPerfFetchStall,
  output logic [PERF_W-1:0] oPerfDAcc,
`endif
  input  logic        iMemWait
);

  dstate_t     dState;
  dstate_t     dNext;
  logic        dReq;
  logic        gntI;
  logic        acceptI;
  logic        memRead;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memByteEn;
  logic        dWait;

  // A simultaneous read+write request is treated as a write.
  assign dReq = iDbusRead | iDbusWe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dState <= D_IDLE;
    end else begin
      dState <= dNext;
    end
  end

  always_comb begin
    dNext     = dState;
    memRead   = 1'b0;
    memWe     = 1'b0;
    memAddr   = iDbusAddr;
    memByteEn = iDbusByteEn;
    dWait     = 1'b0;
    gntI      = 1'b0;
    unique case (dState)
      D_IDLE: begin
        if (dReq) begin
          memWe   = iDbusWe;
          memRead = !iDbusWe;
          // Stores finish on acceptance, loads wait for data.
          dWait   = iMemWait | !iDbusWe;
          if (!iMemWait && !iDbusWe) begin
            dNext = D_RESP;
          end
        end
      end
      D_RESP: begin
        dNext = D_IDLE;
      end
      default: begin
        dNext = D_IDLE;
      end
    endcase
    // The load response cycle leaves the port free for a fetch.
    gntI = !iFetchHold & ((dState == D_RESP) | !dReq);
    if (gntI) begin
      memRead   = 1'b1;
      memAddr   = iIbusAddr;
      memByteEn = 4'hF;
    end
  end

  assign acceptI    = rst_n & gntI & !iMemWait;
  assign oIbusWait  = !acceptI;
  assign oMemRead   = rst_n & memRead;
  assign oMemWe     = rst_n & memWe;
  assign oDbusWait  = !rst_n | dWait;
  assign oMemAddr   = memAddr;
  assign oMemByteEn = memByteEn;
  assign oMemData   = iDbusData;
  assign oDbusData  = iMemData;

  risac_fetch_buf #(
    .NOP_INSTR(NOP_INSTR)
  ) u_fetch_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .acceptI   (acceptI),
    .iIbusAddr (iIbusAddr),
    .iMemData  (iMemData),
    .oIbusData (oIbusData),
    .oIbusIAddr(oIbusIAddr)
  );

`ifdef RISAC_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oPerfFetchStall <= '0;
      oPerfDAcc       <= '0;
    end else begin
      if (oIbusWait && !iFetchHold) begin
        oPerfFetchStall <= oPerfFetchStall + 1'b1;
      end
      if (!oDbusWait && dReq) begin
        oPerfDAcc <= oPerfDAcc + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_risac_mem_arbiter.sv
// tb_risac_mem_arbiter: scoreboard bench for the risac memory arbiter.
// Fetch and load results are queued at issue and compared on delivery.
module tb_risac_mem_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] iIbusAddr = '0;
  logic [31:0] oIbusData;
  logic [31:0] oIbusIAddr;
  logic        oIbusWait;
  logic        iFetchHold = 1'b0;
  logic [31:0] iDbusAddr = '0;
  logic        iDbusWe = 1'b0;
  logic [31:0] iDbusData = '0;
  logic        iDbusRead = 1'b0;
  logic [3:0]  iDbusByteEn = 4'hF;
  logic [31:0] oDbusData;
  logic        oDbusWait;
  logic [31:0] oMemAddr;
  logic        oMemRead;
  logic        oMemWe;
  logic [31:0] oMemData;
  logic [3:0]  oMemByteEn;
  logic [31:0] iMemData = '0;
  logic        iMemWait = 1'b0;
`ifdef RISAC_ARB_PERF_EN
  logic [31:0] oPerfFetchStall;
  logic [31:0] oPerfDAcc;
`endif

  int nCmp = 0;
  int nErr = 0;

  logic [31:0] mem [0:255];
  logic [63:0] fq [$];
  logic [31:0] dq [$];
  logic        accLast = 1'b0;

  risac_mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iIbusAddr  (iIbusAddr),
    .oIbusData  (oIbusData),
    .oIbusIAddr (oIbusIAddr),
    .oIbusWait  (oIbusWait),
    .iFetchHold (iFetchHold),
    .iDbusAddr  (iDbusAddr),
    .iDbusWe    (iDbusWe),
    .iDbusData  (iDbusData),
    .iDbusRead  (iDbusRead),
    .iDbusByteEn(iDbusByteEn),
    .oDbusData  (oDbusData),
    .oDbusWait  (oDbusWait),
    .oMemAddr   (oMemAddr),
    .oMemRead   (oMemRead),
    .oMemWe     (oMemWe),
    .oMemData   (oMemData),
    .oMemByteEn (oMemByteEn),
    .iMemData   (iMemData),
`ifdef RISAC_ARB_PERF_EN
    .oPerfFetchStall(oPerfFetchStall),
    .oPerfDAcc      (oPerfDAcc),
`endif
    .iMemWait   (iMemWait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: 1-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (oMemRead && !iMemWait) iMemData <= mem[oMemAddr[9:2]];
    if (oMemWe && !iMemWait) begin
      for (int b = 0; b < 4; b++)
        if (oMemByteEn[b])
          mem[oMemAddr[9:2]][8*b +: 8] <= oMemData[8*b +: 8];
    end
  end

  // Fetch scoreboard: the instruction consumed on each accept is the
  // previous accepted fetch (or NOP right after reset).
  always @(negedge clk) begin
    if (!rst_n) begin
      fq.delete();
      fq.push_back({32'h0, NOP});
      accLast = 1'b0;
    end else begin
      accLast = !oIbusWait;
      if (!oIbusWait) begin
        if (fq.size() == 0) chk("fetch_q_empty", 64'd1, 64'd0);
        else chk("fetch", {oIbusIAddr, oIbusData}, fq.pop_front());
        fq.push_back({iIbusAddr, mem[iIbusAddr[9:2]]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (accLast) iIbusAddr = iIbusAddr + 32'd4;
  endtask

  task automatic doLoad(input logic [31:0] a);
    bit got = 0;
    iDbusRead = 1'b1;
    iDbusAddr = a;
    dq.push_back(mem[a[9:2]]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!oDbusWait) begin
        got = 1;
        break;
      end
      tick();
    end
    if (!got) chk("load_timeout", 64'd0, 64'd1);
    else chk("load", {32'h0, oDbusData}, {32'h0, dq.pop_front()});
    tick();
    iDbusRead = 1'b0;
  endtask

  logic [63:0] e;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    mem[8'h40] = 32'hDEAD_BEEF;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_memRead", {63'h0, oMemRead}, 64'd0);
    chk("rst_memWe", {63'h0, oMemWe}, 64'd0);
    chk("rst_ibusWait", {63'h0, oIbusWait}, 64'd1);
    chk("rst_dbusWait", {63'h0, oDbusWait}, 64'd1);
    chk("rst_instr", {oIbusIAddr, oIbusData}, {32'h0, NOP});

    // 1: first fetch after release
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_memRead", {63'h0, oMemRead}, 64'd1);
    chk("t1_memAddr", {32'h0, oMemAddr}, 64'h0);
    chk("t1_ibusWait", {63'h0, oIbusWait}, 64'd0);
    chk("t1_nop", {32'h0, oIbusData}, {32'h0, NOP});
    tick();
    @(negedge clk);
    chk("t1_first", {oIbusIAddr, oIbusData}, {32'h0, 32'hA000_0000});

    // 2: load 0x100
    tick();
    iDbusRead = 1'b1;
    iDbusAddr = 32'h100;
    dq.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("t2_memAddr", {32'h0, oMemAddr}, 64'h100);
    chk("t2_dWait", {63'h0, oDbusWait}, 64'd1);
    chk("t2_iWait", {63'h0, oIbusWait}, 64'd1);
    tick();
    @(negedge clk);
    chk("t2_data", {32'h0, oDbusData}, {32'h0, dq.pop_front()});
    chk("t2_dWait_lo", {63'h0, oDbusWait}, 64'd0);
    chk("t2_fetch_gnt", {63'h0, oIbusWait}, 64'd0);

    // 3: byte store with fetch pending
    tick();
    iDbusRead = 1'b0;
    iDbusWe = 1'b1;
    iDbusAddr = 32'h104;
    iDbusData = 32'h55;
    iDbusByteEn = 4'h1;
    e = fq[0];
    @(negedge clk);
    chk("t3_memWe", {63'h0, oMemWe}, 64'd1);
    chk("t3_be", {60'h0, oMemByteEn}, 64'h1);
    chk("t3_dWait", {63'h0, oDbusWait}, 64'd0);
    chk("t3_iWait", {63'h0, oIbusWait}, 64'd1);
    chk("t3_pres0", {oIbusIAddr, oIbusData}, e);
    tick();
    iDbusWe = 1'b0;
    iDbusByteEn = 4'hF;
    @(negedge clk);
    chk("t3_pres1", {oIbusIAddr, oIbusData}, e);

    // 4: fetch hold for 3 cycles
    tick();
    iFetchHold = 1'b1;
    e = fq[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_iWait", {63'h0, oIbusWait}, 64'd1);
      chk("t4_held", {oIbusIAddr, oIbusData}, e);
      tick();
    end
    iFetchHold = 1'b0;
    @(negedge clk);
    chk("t4_release", {oIbusIAddr, oIbusData}, e);

    // 5: load with 2 memory wait cycles; reads back the stored byte
    tick();
    iDbusRead = 1'b1;
    iDbusAddr = 32'h104;
    iMemWait = 1'b1;
    dq.push_back(32'hA000_0055);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) iMemWait = 1'b0;
      @(negedge clk);
      chk("t5_dWait", {63'h0, oDbusWait}, 64'd1);
      chk("t5_iWait", {63'h0, oIbusWait}, 64'd1);
      tick();
    end
    @(negedge clk);
    chk("t5_dWait_lo", {63'h0, oDbusWait}, 64'd0);
    chk("t5_data", {32'h0, oDbusData}, {32'h0, dq.pop_front()});
    tick();
    iDbusRead = 1'b0;

    // Random fetch/hold/wait traffic with occasional loads
    for (int n = 0; n < 60; n++) begin
      iFetchHold = ($urandom_range(0, 3) == 0);
      iMemWait = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        iMemWait = 1'b0;
        doLoad({22'h0, 8'($urandom_range(0, 255)), 2'b00});
      end else begin
        tick();
      end
    end
    iFetchHold = 1'b0;
    iMemWait = 1'b0;

    // 6: reset in the D_RESP cycle
    tick();
    iDbusRead = 1'b1;
    iDbusAddr = 32'h100;
    @(negedge clk);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_memRead", {63'h0, oMemRead}, 64'd0);
    chk("t6_memWe", {63'h0, oMemWe}, 64'd0);
    chk("t6_iWait", {63'h0, oIbusWait}, 64'd1);
    chk("t6_dWait", {63'h0, oDbusWait}, 64'd1);
    chk("t6_rst_instr", {oIbusIAddr, oIbusData}, {32'h0, NOP});
    iDbusRead = 1'b0;
    iIbusAddr = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_nop", {oIbusIAddr, oIbusData}, {32'h0, NOP});
    chk("t6_iWait_lo", {63'h0, oIbusWait}, 64'd0);
    repeat (4) tick();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/risac_mem_arbiter.md
Name: risac_mem_arbiter

Overview:
Shares one single-port, fixed-latency memory between the risac core's instruction bus and data bus, so the core can run from a unified code/data RAM.
- Data accesses have absolute priority; fetches use every cycle the data side leaves free.
- Generates the core's iIbusWait and iDbusWait.
- Re-aligns read data with the core's "data valid in the cycle wait is low" convention.
- Sits at top level between the core and the memory.

Parameters:
NOP_INSTR, 32'h00000013, instruction presented when no fetch response exists (addi x0,x0,0)
PERF_W, 32, width of performance counters (used only with RISAC_ARB_PERF_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
iIbusAddr  in  32  fetch address (core pc)
oIbusData  out  32  instruction presented to decode
oIbusIAddr  out  32  address of oIbusData
oIbusWait  out  1  1 = fetch not accepted, presented instruction not consumed
iFetchHold  in  1  core not advancing pc this cycle (dataHazard | stallPipe)
iDbusAddr  in  32  data address
iDbusWe  in  1  store request
iDbusData  in  32  store data
iDbusRead  in  1  load request
iDbusByteEn  in  4  byte enables
oDbusData  out  32  load data
oDbusWait  out  1  data access not complete
oMemAddr  out  32  memory address
oMemRead  out  1  memory read strobe
oMemWe  out  1  memory write strobe
oMemData  out  32  memory write data
oMemByteEn  out  4  memory byte enables
iMemData  in  32  read data, valid exactly 1 cycle after an accepted read
iMemWait  in  1  memory cannot accept request this cycle

Behaviour:
- Reset is asynchronous (rst_n active-low); clock is clk.
- While rst_n is low:
  - oMemRead = oMemWe = 0; oIbusWait = oDbusWait = 1.
  - All registers clear: dState = D_IDLE, fetchPend = 0, hValid = 0, pendAddr = hAddr = 0.
  - oIbusData = NOP_INSTR, oIbusIAddr = 0, oDbusData = iMemData.
- dReq = iDbusRead | iDbusWe. If both are high, the access is a write.
- D FSM:
  - D_IDLE, dReq, !iMemWait:
    - Write: port driven with the D signals; oDbusWait = 0 in the same cycle; stay in D_IDLE.
    - Read: port driven with the D signals; oDbusWait = 1; go to D_RESP.
  - D_IDLE, dReq, iMemWait: D signals driven; oDbusWait = 1; stay.
  - D_RESP: oDbusData = iMemData, oDbusWait = 0; D does not use the port; go to D_IDLE.
  - Every load therefore costs exactly 1 core stall cycle (more if iMemWait).
- Fetch grant:
  - gntI = !iFetchHold & (dState == D_RESP | !dReq).
  - When gntI: oMemRead = 1, oMemAddr = iIbusAddr, oMemByteEn = 4'hF.
  - acceptI = gntI & !iMemWait; oIbusWait = !acceptI.
  - oIbusWait is 1 whenever oDbusWait is 1, because the core is stalled in those cycles.
- Fetch response (one-entry stream, at most one unconsumed instruction):
  - Registers: fetchPend <= acceptI; pendAddr <= iIbusAddr when acceptI.
  - Presented value: fetchPend ? {pendAddr, iMemData} : hValid ? {hAddr, hData} : {hAddr, NOP_INSTR}.
  - fetchPend & !acceptI: hold register captures {pendAddr, iMemData}; hValid <= 1.
  - acceptI: presented instruction is consumed; hValid <= 0.
  - fetchPend and dState == D_RESP are mutually exclusive, so iMemData is never ambiguous.
- Memory strobes are combinational from the current state and inputs; reads return data with a fixed latency of 1 cycle. Reset mid-access abandons it; the data returned after reset is ignored.

Optional Feature:
RISAC_ARB_PERF_EN:
- Defined: adds outputs oPerfFetchStall[PERF_W-1:0] and oPerfDAcc[PERF_W-1:0], both reset to 0.
  - oPerfFetchStall increments each cycle with oIbusWait = 1 and iFetchHold = 0.
  - oPerfDAcc increments per completed data access (cycle with oDbusWait = 0 and dReq).
  - Both counters wrap at 2^PERF_W.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package risac_arb_pkg: NOP_INSTR default constant; D-state encoding (D_IDLE, D_RESP).
- Sub-module risac_fetch_buf: fetchPend/pendAddr/hold register and the output mux. It takes acceptI, iIbusAddr and iMemData and produces oIbusData/oIbusIAddr.

Test Plan:
1. Reset, then release with iMemWait = 0, no D requests, pc = 0 → first cycle: oMemRead = 1, addr 0, oIbusWait = 0, oIbusData = 0x00000013. Next cycle: oIbusIAddr = 0, oIbusData = mem[0].
2. Load from 0x100 (mem = 0xDEADBEEF) → cycle t: oMemAddr = 0x100, oDbusWait = 1, oIbusWait = 1. Cycle t+1: oDbusData = 0xDEADBEEF, oDbusWait = 0, fetch granted.
3. Store 0x55 to 0x104, byteEn = 4'h1, while a fetch is pending → oMemWe = 1, oDbusWait = 0, oIbusWait = 1. The pending instruction is re-presented unchanged next cycle.
4. iFetchHold = 1 for 3 cycles with fetchPend set → oIbusWait = 1 throughout. The held {addr, data} is stable and is presented when hold drops.
5. iMemWait = 1 for 2 cycles during a load → oDbusWait = 1 for 3 cycles, then data is returned. No fetch is accepted meanwhile.
6. Assert rst_n low in the D_RESP cycle → strobes drop immediately; after release, the first instruction presented is NOP_INSTR.
